// File: rtl/conv_stream_tx_if.sv
// conv_stream_tx_if: AXI-stream link from the host transmitter into the Conv accelerator.
// tdata  [INW]       stream word
// tvalid [1]         word valid (master)
// tuser  [K_BITS+1]  {K, new-W flag}
// tready [1]         sink ready (slave)
interface conv_stream_tx_if #(
    parameter int INW = 18,
    parameter int K_BITS = 3
);
    logic [INW-1:0] tdata;
    logic tvalid;
    logic [K_BITS:0] tuser;
    logic tready;
    modport master(output tdata, tvalid, tuser, input tready);
    modport slave(input tdata, tvalid, tuser, output tready);
endinterface

// File: rtl/conv_stream_tx.sv
// conv_stream_tx: host-side source that streams W, B and X into the Conv input AXI-stream.
// clk, reset                 clock, synchronous active-high reset
// wr_en/wr_sel/wr_addr/wr_data  host write port (sel 0 = W, 1 = X), ignored while busy
// b_value, k_value, send_w   transfer settings, sampled on an accepted start
// start                      begin a transfer (pulse)
// busy, done, err            status: transfer active, end pulse, rejected-start pulse
// axis                       stream master: tdata/tvalid/tuser out, tready in
module conv_stream_tx #(
    parameter int INW = 18,
    parameter int R = 8,
    parameter int C = 8,
    parameter int MAXK = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic                       wr_sel,
    input  logic [$clog2(R*C)-1:0]     wr_addr,
    input  logic [INW-1:0]             wr_data,
    input  logic [INW-1:0]             b_value,
    input  logic [$clog2(MAXK+1)-1:0]  k_value,
    input  logic                       send_w,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    conv_stream_tx_if.master           axis
);
    localparam int K_BITS = $clog2(MAXK+1);
    localparam int AW = $clog2(R*C);
    localparam int WAW = $clog2(MAXK*MAXK);
    localparam int CW = $clog2(R*C+1);
    localparam logic [CW-1:0] X_LAST = CW'(R*C-1);

    typedef enum logic [2:0] {IDLE, SEND_W, SEND_B, SEND_X, DONE} state_t;

    state_t state, p_seg;
    logic [INW-1:0] w_mem [MAXK*MAXK];
    logic [INW-1:0] x_mem [R*C];
    logic [INW-1:0] w_q, x_q, b_reg, sk_data, in_data;
    logic [K_BITS-1:0] k_reg;
    logic [CW-1:0] idx, w_last;
    logic iss_end, p_v, sk_v, sk_w, in_w, issue, pop, load_out;

    // Items in flight (memory read stage) plus the output register and skid entry
    // never exceed two, so a read is issued only when it is sure to find a slot.
    always_comb begin
        pop = axis.tvalid & axis.tready;
        load_out = ~axis.tvalid | pop;
        issue = (state == SEND_W || state == SEND_B || state == SEND_X) && !iss_end &&
                ({1'b0, axis.tvalid & ~pop} + {1'b0, sk_v} + {1'b0, p_v}) < 2'd2;
        in_data = p_seg == SEND_X ? x_q : p_seg == SEND_W ? w_q : b_reg;
        in_w = p_seg != SEND_X;
    end

    always_ff @(posedge clk) begin
        if (wr_en && !busy && wr_sel)
            x_mem[wr_addr] <= wr_data;
        if (wr_en && !busy && !wr_sel && int'(WAW'(wr_addr)) < MAXK*MAXK)
            w_mem[WAW'(wr_addr)] <= wr_data;
        if (state == SEND_W)
            w_q <= w_mem[WAW'(idx)];
        x_q <= x_mem[AW'(idx)];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            axis.tvalid <= 1'b0;
            axis.tdata <= '0;
            axis.tuser <= '0;
            p_v <= 1'b0;
            sk_v <= 1'b0;
            iss_end <= 1'b0;
            idx <= '0;
        end else begin
            done <= 1'b0;
            err <= 1'b0;
            p_v <= issue;
            if (issue)
                p_seg <= state;
            if (load_out) begin
                axis.tvalid <= sk_v | p_v;
                if (sk_v)
                    {axis.tdata, axis.tuser} <= {sk_data, k_reg, sk_w};
                else if (p_v)
                    {axis.tdata, axis.tuser} <= {in_data, k_reg, in_w};
                sk_v <= sk_v & p_v;
            end else if (p_v) begin
                sk_v <= 1'b1;
            end
            // The arriving read parks in the skid whenever the output register cannot take it.
            if (p_v && (!load_out || sk_v))
                {sk_data, sk_w} <= {in_data, in_w};
            case (state)
                IDLE: if (start) begin
                    if (k_value == '0 || int'(k_value) > MAXK || int'(k_value) > R || int'(k_value) > C) begin
                        err <= 1'b1;
                    end else begin
                        k_reg <= k_value;
                        b_reg <= b_value;
                        w_last <= CW'(k_value * k_value - 1);
                        busy <= 1'b1;
                        idx <= '0;
                        iss_end <= 1'b0;
                        state <= send_w ? SEND_W : SEND_X;
                    end
                end
                SEND_W: if (issue) begin
                    idx <= idx == w_last ? '0 : idx + CW'(1);
                    state <= idx == w_last ? SEND_B : SEND_W;
                end
                SEND_B: if (issue)
                    state <= SEND_X;
                SEND_X: begin
                    if (issue) begin
                        iss_end <= idx == X_LAST;
                        idx <= idx == X_LAST ? idx : idx + CW'(1);
                    end
                    // Last word issued and nothing left behind the beat now leaving.
                    if (iss_end && pop && !sk_v && !p_v) begin
                        state <= DONE;
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
